// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins ties unless fetch has waited STARVE_LIMIT grants; a watchdog aborts hung accesses.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              stall_fetch,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_timeout,
  output logic [1:0]        dbg_state
);
  // Requester handshake: a request is held with stable payload until its done
  // pulse; the request counts as accepted at the IDLE edge where it is granted.
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            owner_dm;
  logic [SC_W-1:0] starve_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic            grant_dm, grant_if, wd_expired, finish;

  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (dm_req && (!if_req || starve_cnt != SC_W'(STARVE_LIMIT))) grant_dm = 1'b1;
    else if (if_req) grant_if = 1'b1;
  end

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
  assign finish     = mem_ack || wd_expired;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_dm || grant_if) state_nxt = BUSY;
      BUSY:    if (finish) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_dm    <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
      if_done     <= 1'b0;
      dm_done     <= 1'b0;
      err_timeout <= 1'b0;
      starve_cnt  <= '0;
      wd_cnt      <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm || grant_if) begin
            owner_dm  <= grant_dm;
            mem_req   <= 1'b1;
            mem_we    <= grant_dm & dm_we;
            mem_addr  <= grant_dm ? dm_addr : if_addr;
            mem_wdata <= grant_dm ? dm_wdata : '0;
            wd_cnt    <= '0;
            // Only a data grant that bypasses a waiting fetch counts toward starvation.
            if (grant_if || !if_req)
              starve_cnt <= '0;
            else if (starve_cnt != SC_W'(STARVE_LIMIT))
              starve_cnt <= starve_cnt + SC_W'(1);
          end
        end
        BUSY: begin
          if (finish) begin
            mem_req <= 1'b0;
            if (!mem_ack) err_timeout <= 1'b1;
            if (owner_dm) begin
              dm_done  <= 1'b1;
              dm_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        RESP:    wd_cnt <= '0;
        default: ;
      endcase
    end
  end

  assign stall_fetch = if_req & ~if_done;
  assign stall_mem   = dm_req & ~dm_done;
  assign dbg_state   = state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences and a
// randomized run checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_done, stall_fetch;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_done, stall_mem;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_req, mem_we, mem_ack, err_timeout;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .stall_fetch(stall_fetch),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err_timeout(err_timeout),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];
  bit            exp_own_q[$];

  typedef struct {
    bit            dm;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            ack_dly;
    logic [DW-1:0] rdata;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    repeat (2) tick();
    rst = 0;
    tick();
  endtask

  task automatic run_single(input vec_t v, input int idx);
    int lat, busy;
    bit done;
    logic [DW-1:0] other;
    if (v.dm) begin dm_req = 1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; end
    else begin if_req = 1; if_addr = v.addr; end
    other = v.dm ? if_rdata : dm_rdata;
    lat = 0; busy = 0; done = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
      if (if_done || dm_done) done = 1;
      else if (mem_req) begin
        chk($sformatf("vec%0d mem_addr", idx), mem_addr, v.addr);
        chk($sformatf("vec%0d mem_we", idx), mem_we, v.dm & v.we);
        if (v.dm) chk($sformatf("vec%0d mem_wdata", idx), mem_wdata, v.wdata);
        chk($sformatf("vec%0d stall", idx), v.dm ? stall_mem : stall_fetch, 1);
        mem_ack = (busy == v.ack_dly);
        mem_rdata = mem_ack ? v.rdata : $urandom;
        busy++;
      end else mem_ack = 0;
    end
    mem_ack = 0;
    chk($sformatf("vec%0d done seen", idx), done, 1);
    chk($sformatf("vec%0d latency", idx), lat, v.exp_lat);
    chk($sformatf("vec%0d done side", idx), {if_done, dm_done}, v.dm ? 2'b01 : 2'b10);
    chk($sformatf("vec%0d rdata", idx), v.dm ? dm_rdata : if_rdata, v.exp_rdata);
    chk($sformatf("vec%0d other rdata held", idx), v.dm ? if_rdata : dm_rdata, other);
    if_req = 0; dm_req = 0;
    tick();
    chk($sformatf("vec%0d done cleared", idx), {if_done, dm_done}, 2'b00);
    chk($sformatf("vec%0d rdata held", idx), v.dm ? dm_rdata : if_rdata, v.exp_rdata);
    chk($sformatf("vec%0d stalls low", idx), {stall_fetch, stall_mem}, 2'b00);
    chk($sformatf("vec%0d err_timeout", idx), err_timeout, 0);
  endtask

  initial begin
    int grants, cnt, lat;
    bit mreq_q, got;
    vec_t v;

    vecs[0] = '{0, 0, 32'h0000_0010, 32'h0,         1, 32'h0050_0093, 32'h0050_0093, 3};
    vecs[1] = '{0, 0, 32'h0000_0014, 32'h0,         0, 32'h00A0_0113, 32'h00A0_0113, 2};
    vecs[2] = '{1, 0, 32'h0000_0200, 32'h0,         2, 32'h1234_5678, 32'h1234_5678, 4};
    vecs[3] = '{1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'hFFFF_0000, 32'h0,         2};
    vecs[4] = '{0, 0, 32'h0000_0018, 32'h0,         6, 32'h0000_0013, 32'h0000_0013, 8};
    vecs[5] = '{1, 1, 32'h0000_0104, 32'h0BAD_CAFE, 3, 32'h1111_2222, 32'h0,         5};
    vecs[6] = '{1, 0, 32'h0000_0208, 32'h0,         5, 32'hCAFE_F00D, 32'hCAFE_F00D, 7};

    rst = 1;
    idle_inputs();
    #1;
    chk("reset mem_req", mem_req, 0);
    chk("reset dones", {if_done, dm_done}, 2'b00);
    chk("reset mem_addr/wdata", {mem_addr, mem_wdata}, 64'h0);
    chk("reset rdata", {if_rdata, dm_rdata}, 64'h0);
    chk("reset err/we", {err_timeout, mem_we}, 2'b00);
    chk("reset state", dbg_state, 0);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      run_single(v, i);
      tick();
    end

    // Simultaneous store and fetch: data first, fetch afterwards.
    if_req = 1; if_addr = 32'h40;
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    tick();
    chk("prio first addr", mem_addr, 32'h100);
    chk("prio first we", mem_we, 1);
    chk("prio first wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_ack = 1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 0;
    chk("prio dm_done", {if_done, dm_done}, 2'b01);
    chk("prio dm_rdata store", dm_rdata, 0);
    chk("prio stalls", {stall_fetch, stall_mem}, 2'b10);
    dm_req = 0;
    tick();
    chk("prio idle gap", mem_req, 0);
    tick();
    chk("prio second addr", mem_addr, 32'h40);
    chk("prio second we", mem_we, 0);
    mem_ack = 1; mem_rdata = 32'h0000_0077;
    tick();
    mem_ack = 0;
    chk("prio if_done", {if_done, dm_done}, 2'b10);
    chk("prio if_rdata", if_rdata, 32'h77);
    if_req = 0;
    tick();

    // Starvation: both held high, zero-wait acks.
    if_req = 1; if_addr = 32'h1000;
    dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
    grants = 0; mreq_q = 0;
    for (int c = 0; c < 200 && grants < 10; c++) begin
      tick();
      if (mem_req && !mreq_q) begin
        chk($sformatf("starve grant %0d", grants), mem_addr,
            (grants % 5 == 4) ? 32'h1000 : 32'h2000);
        grants++;
        mem_ack = 1; mem_rdata = 32'hA5A5_0000 + grants;
      end else mem_ack = 0;
      mreq_q = mem_req;
    end
    chk("starve grant count", grants, 10);
    tick();
    if_req = 0; dm_req = 0; mem_ack = 0;
    repeat (3) tick();

    // Watchdog abort on a load that is never acknowledged.
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    cnt = 0; got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      tick();
      mem_rdata = $urandom;
      if (dm_done) got = 1;
      else if (mem_req) cnt++;
    end
    chk("timeout done", got, 1);
    chk("timeout mem_req cycles", cnt, TO);
    chk("timeout dm_rdata", dm_rdata, 0);
    chk("timeout err flag", err_timeout, 1);
    dm_req = 0;
    repeat (2) tick();
    mem_ack = 1; mem_rdata = 32'h99;
    repeat (2) begin
      tick();
      chk("stray ack no done", {if_done, dm_done, mem_req}, 3'b000);
      chk("stray ack state", dbg_state, 0);
    end
    mem_ack = 0;
    chk("stray ack dm_rdata", dm_rdata, 0);
    chk("err sticky", err_timeout, 1);

    // Reset asserted mid-transaction.
    if_req = 1; if_addr = 32'h80;
    tick();
    chk("rst-busy mem_req up", mem_req, 1);
    tick();
    #2 rst = 1;
    #1;
    chk("rst-busy mem_req async", mem_req, 0);
    chk("rst-busy err cleared", err_timeout, 0);
    chk("rst-busy state", dbg_state, 0);
    tick();
    chk("rst-busy no done", {if_done, dm_done}, 2'b00);
    rst = 0;
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      tick();
      lat++;
      if (if_done) got = 1;
      else if (mem_req) begin
        chk("rst-busy regrant addr", mem_addr, 32'h80);
        mem_ack = 1; mem_rdata = 32'h0000_BEEF;
      end else mem_ack = 0;
    end
    mem_ack = 0;
    chk("rst-busy regrant done", got, 1);
    chk("rst-busy regrant latency", lat, 2);
    chk("rst-busy if_rdata", if_rdata, 32'hBEEF);
    if_req = 0;
    tick();

    // Randomized traffic against the arbitration model.
    do_reset();
    begin
      bit p_if, p_dm, cur_dm, c_we, o;
      int s_cnt, wait_n, busy_n, n_done;
      logic [AW-1:0] c_addr;
      logic [DW-1:0] c_wdata, rd, e;
      p_if = 0; p_dm = 0; mreq_q = 0; s_cnt = 0; n_done = 0;
      cur_dm = 0; c_we = 0; c_addr = '0; c_wdata = '0; wait_n = 0; busy_n = 0;
      for (int c = 0; c < 3000; c++) begin
        tick();
        chk("rnd stall_fetch", stall_fetch, if_req & ~if_done);
        chk("rnd stall_mem", stall_mem, dm_req & ~dm_done);
        if (mem_req) begin
          if (!mreq_q) begin
            if (p_dm && (!p_if || s_cnt < SL)) begin
              cur_dm = 1;
              s_cnt = p_if ? s_cnt + 1 : 0;
            end else if (p_if) begin
              cur_dm = 0;
              s_cnt = 0;
            end else begin
              chk("rnd spurious grant", 1, 0);
              cur_dm = 0;
            end
            c_we = cur_dm ? dm_we : 1'b0;
            c_addr = cur_dm ? dm_addr : if_addr;
            c_wdata = dm_wdata;
            busy_n = 0;
            wait_n = $urandom_range(0, 3);
          end
          chk("rnd mem_addr", mem_addr, c_addr);
          chk("rnd mem_we", mem_we, c_we);
          if (cur_dm && c_we) chk("rnd mem_wdata", mem_wdata, c_wdata);
          rd = $urandom;
          mem_rdata = rd;
          if (busy_n == wait_n) begin
            mem_ack = 1;
            exp_q.push_back((cur_dm && c_we) ? '0 : rd);
            exp_own_q.push_back(cur_dm);
          end else mem_ack = 0;
          busy_n++;
        end else begin
          mem_ack = 0;
          mem_rdata = $urandom;
        end
        mreq_q = mem_req;
        if (if_done || dm_done) begin
          n_done++;
          chk("rnd single done", if_done & dm_done, 0);
          if (exp_q.size() == 0) chk("rnd unexpected done", 1, 0);
          else begin
            e = exp_q.pop_front();
            o = exp_own_q.pop_front();
            chk("rnd done owner", dm_done, o);
            chk("rnd rdata", o ? dm_rdata : if_rdata, e);
          end
          if (if_done) if_req = 0;
          if (dm_done) dm_req = 0;
        end
        if (!if_req && $urandom_range(0, 2) == 0) begin
          if_req = 1;
          if_addr = $urandom & 32'h0000_FFFC;
        end
        if (!dm_req && $urandom_range(0, 2) == 0) begin
          dm_req = 1;
          dm_we = $urandom_range(0, 1);
          dm_addr = $urandom & 32'h0000_FFFC;
          dm_wdata = $urandom;
        end
        p_if = if_req;
        p_dm = dm_req;
      end
      chk("rnd enough completions", n_done > 200, 1);
      chk("rnd no timeout", err_timeout, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
